// File: rtl/gbt_link_init_fsm.sv
// GBT link bring-up sequencer: steps the GTX and GBT TX/RX resets against QPLL lock,
// transceiver reset-done flags and header lock, with timeouts, bounded retries and a sticky error.
module gbt_link_init_fsm #(
  parameter int unsigned RST_LEN   = 16,
  parameter logic [19:0] LOCK_TMO  = 20'hFFFFF,
  parameter int unsigned MAX_RETRY = 8,
  parameter int unsigned LOSS_FILT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       QPLL_LOCK,
  input  logic       TX_RST_DONE,
  input  logic       RX_RST_DONE,
  input  logic       RX_HDR_LOCKED,
  output logic       GTX_TX_RST,
  output logic       GTX_RX_RST,
  output logic       GBT_TX_RST,
  output logic       GBT_RX_RST,
  output logic       LINK_READY,
  output logic       ERR,
  output logic [7:0] RETRY_CNT
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W4QPLL,
    S_TXRST,
    S_W4TXDONE,
    S_RXRST,
    S_W4RXDONE,
    S_W4LOCK,
    S_READY,
    S_FAIL
  } state_t;

  localparam logic [19:0] RST_END   = 20'(RST_LEN - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
  localparam logic [7:0]  LOSS_END  = 8'(LOSS_FILT);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] timer;
  logic [7:0]  cons_cnt;
  logic [7:0]  cons_nxt;
  logic [7:0]  loss_cnt;
  logic        retry;
  logic        loss_retry;
  logic [4:0]  rst_vec;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    retry      = 1'b0;
    loss_retry = 1'b0;

    if (state == S_FAIL) begin
      state_nxt = S_FAIL;
    end else if (!RUN) begin
      state_nxt = S_IDLE;
    end else if (!QPLL_LOCK && state != S_IDLE && state != S_W4QPLL) begin
      state_nxt = S_W4QPLL;
    end else begin
      unique case (state)
        S_IDLE:     state_nxt = S_W4QPLL;
        S_W4QPLL:   if (QPLL_LOCK) state_nxt = S_TXRST;
        S_TXRST:    if (timer == RST_END) state_nxt = S_W4TXDONE;
        S_W4TXDONE: begin
          if (TX_RST_DONE) begin
            state_nxt = S_RXRST;
          end else if (timer == LOCK_TMO) begin
            state_nxt = S_TXRST;
            retry     = 1'b1;
          end
        end
        S_RXRST:    if (timer == RST_END) state_nxt = S_W4RXDONE;
        S_W4RXDONE: begin
          if (RX_RST_DONE) begin
            state_nxt = S_W4LOCK;
          end else if (timer == LOCK_TMO) begin
            state_nxt = S_RXRST;
            retry     = 1'b1;
          end
        end
        S_W4LOCK: begin
          if (RX_HDR_LOCKED) begin
            state_nxt = S_READY;
          end else if (timer == LOCK_TMO) begin
            state_nxt = S_RXRST;
            retry     = 1'b1;
          end
        end
        S_READY: begin
          if (loss_cnt == LOSS_END) begin
            state_nxt  = S_RXRST;
            retry      = 1'b1;
            loss_retry = 1'b1;
          end
        end
        default:    state_nxt = S_IDLE;
      endcase
    end

    // A link loss opens a fresh run of consecutive failures.
    cons_nxt = loss_retry ? 8'd1 : cons_cnt + 8'd1;
    if (retry && cons_nxt == RETRY_LIM) state_nxt = S_FAIL;
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    rst_vec = 5'b11110;
    case (state_nxt)
      S_W4TXDONE: rst_vec = 5'b01110;
      S_RXRST:    rst_vec = 5'b01010;
      S_W4RXDONE: rst_vec = 5'b00010;
      S_W4LOCK:   rst_vec = 5'b00000;
      S_READY:    rst_vec = 5'b00001;
      default:    rst_vec = 5'b11110;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      timer      <= '0;
      cons_cnt   <= '0;
      loss_cnt   <= '0;
      RETRY_CNT  <= '0;
      ERR        <= 1'b0;
      {GTX_TX_RST, GTX_RX_RST, GBT_TX_RST, GBT_RX_RST, LINK_READY} <= 5'b11110;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : timer + 20'd1;

      if (retry) begin
        cons_cnt <= cons_nxt;
      end else if (state_nxt == S_READY && state != S_READY) begin
        cons_cnt <= '0;
      end

      loss_cnt <= (state == S_READY && state_nxt == S_READY && !RX_HDR_LOCKED)
                  ? loss_cnt + 8'd1 : 8'd0;

      if (retry && RETRY_CNT != 8'hFF) RETRY_CNT <= RETRY_CNT + 8'd1;
      if (state_nxt == S_FAIL) ERR <= 1'b1;

      {GTX_TX_RST, GTX_RX_RST, GBT_TX_RST, GBT_RX_RST, LINK_READY} <= rst_vec;
    end
  end

endmodule

// File: tb/tb_gbt_link_init_fsm.sv
// Bench for gbt_link_init_fsm: directed scenarios plus random stimulus, each cycle compared
// against a phase/dwell-time reference model of the bring-up sequence.
module tb_gbt_link_init_fsm;

  localparam int T_RST_LEN   = 16;
  localparam int T_LOCK_TMO  = 100;
  localparam int T_MAX_RETRY = 3;
  localparam int T_LOSS_FILT = 4;

  localparam logic [13:0] RESET_OUT  = 14'b11110_0_00000000;
  localparam logic [13:0] FAIL_OUT   = 14'b11110_1_00000011;
  localparam logic [13:0] W4LOCK_OUT = 14'b00000_0_00000000;
  localparam logic [13:0] W4RX_OUT   = 14'b00010_0_00000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       qpll = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_done = 1'b0;
  logic       hdr = 1'b0;
  logic       gtx_tx_rst, gtx_rx_rst, gbt_tx_rst, gbt_rx_rst, link_ready, err;
  logic [7:0] retry_cnt;
  logic [13:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gbt_link_init_fsm #(
    .RST_LEN  (T_RST_LEN),
    .LOCK_TMO (20'(T_LOCK_TMO)),
    .MAX_RETRY(T_MAX_RETRY),
    .LOSS_FILT(T_LOSS_FILT)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .RUN          (run),
    .QPLL_LOCK    (qpll),
    .TX_RST_DONE  (tx_done),
    .RX_RST_DONE  (rx_done),
    .RX_HDR_LOCKED(hdr),
    .GTX_TX_RST   (gtx_tx_rst),
    .GTX_RX_RST   (gtx_rx_rst),
    .GBT_TX_RST   (gbt_tx_rst),
    .GBT_RX_RST   (gbt_rx_rst),
    .LINK_READY   (link_ready),
    .ERR          (err),
    .RETRY_CNT    (retry_cnt)
  );

  assign obs = {gtx_tx_rst, gtx_rx_rst, gbt_tx_rst, gbt_rx_rst, link_ready, err, retry_cnt};

  // ---------------- reference model: phase plus cycles spent in it ----------------
  localparam int P_IDLE = 0, P_QPLL = 1, P_TXRST = 2, P_TXDONE = 3, P_RXRST = 4,
                 P_RXDONE = 5, P_LOCK = 6, P_READY = 7, P_FAIL = 8;

  int m_phase  = P_IDLE;
  int m_enter  = 0;
  int m_cyc    = 0;
  int m_consec = 0;
  int m_total  = 0;
  bit m_err    = 1'b0;
  bit hdr_hist[$];

  always @(posedge clk) begin : ref_model
    int np, dwell, c;
    bit do_retry, from_loss, lost;
    m_cyc++;
    if (rst) begin
      m_phase = P_IDLE; m_enter = m_cyc; m_consec = 0; m_total = 0; m_err = 1'b0;
      hdr_hist.delete();
    end else begin
      dwell = m_cyc - m_enter;
      np = m_phase; do_retry = 1'b0; from_loss = 1'b0;
      lost = (hdr_hist.size() == T_LOSS_FILT);
      foreach (hdr_hist[i]) if (hdr_hist[i]) lost = 1'b0;
      if (m_phase == P_FAIL) np = P_FAIL;
      else if (!run) np = P_IDLE;
      else if (!qpll && m_phase != P_IDLE && m_phase != P_QPLL) np = P_QPLL;
      else begin
        case (m_phase)
          P_IDLE:   np = P_QPLL;
          P_QPLL:   if (qpll) np = P_TXRST;
          P_TXRST:  if (dwell == T_RST_LEN) np = P_TXDONE;
          P_TXDONE: if (tx_done) np = P_RXRST;
                    else if (dwell == T_LOCK_TMO + 1) begin np = P_TXRST; do_retry = 1'b1; end
          P_RXRST:  if (dwell == T_RST_LEN) np = P_RXDONE;
          P_RXDONE: if (rx_done) np = P_LOCK;
                    else if (dwell == T_LOCK_TMO + 1) begin np = P_RXRST; do_retry = 1'b1; end
          P_LOCK:   if (hdr) np = P_READY;
                    else if (dwell == T_LOCK_TMO + 1) begin np = P_RXRST; do_retry = 1'b1; end
          P_READY:  if (lost) begin np = P_RXRST; do_retry = 1'b1; from_loss = 1'b1; end
          default:  np = P_IDLE;
        endcase
      end
      if (do_retry) begin
        if (m_total < 255) m_total++;
        c = from_loss ? 1 : m_consec + 1;
        if (c == T_MAX_RETRY) np = P_FAIL;
        else m_consec = c;
      end
      if (np == P_READY && m_phase != P_READY) m_consec = 0;
      if (np == P_FAIL) m_err = 1'b1;
      if (np == P_READY && m_phase == P_READY) begin
        hdr_hist.push_back(hdr);
        if (hdr_hist.size() > T_LOSS_FILT) void'(hdr_hist.pop_front());
      end else begin
        hdr_hist.delete();
      end
      if (np != m_phase) m_enter = m_cyc;
      m_phase = np;
    end
  end

  function automatic logic [13:0] model_out();
    logic [4:0] r;
    case (m_phase)
      P_TXDONE: r = 5'b01110;
      P_RXRST:  r = 5'b01010;
      P_RXDONE: r = 5'b00010;
      P_LOCK:   r = 5'b00000;
      P_READY:  r = 5'b00001;
      default:  r = 5'b11110;
    endcase
    return {r, m_err, 8'(m_total)};
  endfunction

  // ---------------- stimulus helper ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    qpll = 1'($urandom); tx_done = 1'($urandom); rx_done = 1'($urandom); hdr = 1'($urandom);
    apply_reset();
    checks++;
    if (obs !== RESET_OUT) begin
      errors++; $display("FAIL reset_state got=%b want=%b", obs, RESET_OUT);
    end
    checks++;
    if (obs !== model_out()) begin
      errors++; $display("FAIL reset_model got=%b want=%b", obs, model_out());
    end
  endtask

  task automatic test_bringup();
    int ready_at, tx_fall, rx_fall;
    apply_reset();
    qpll = 1; tx_done = 1; rx_done = 1; hdr = 1; run = 1;
    ready_at = 0; tx_fall = 0; rx_fall = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL bringup cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (link_ready && ready_at == 0) ready_at = n;
      if (!gtx_tx_rst && tx_fall == 0) tx_fall = n;
      if (!gtx_rx_rst && rx_fall == 0) rx_fall = n;
    end
    checks++;
    if (ready_at != 37) begin errors++; $display("FAIL bringup_ready_cycle got=%0d want=37", ready_at); end
    checks++;
    if (tx_fall != 18) begin errors++; $display("FAIL bringup_gtx_tx_fall got=%0d want=18", tx_fall); end
    checks++;
    if (rx_fall != 35) begin errors++; $display("FAIL bringup_gtx_rx_fall got=%0d want=35", rx_fall); end
    checks++;
    if (retry_cnt !== 8'd0) begin errors++; $display("FAIL bringup_retry got=%0d want=0", retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    int tx_entries, fail_at;
    logic prev_tx;
    apply_reset();
    qpll = 1; tx_done = 0; rx_done = 1; hdr = 1; run = 1;
    tx_entries = 0; fail_at = 0; prev_tx = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL timeout cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (gtx_tx_rst && !prev_tx && !err) tx_entries++;
      prev_tx = gtx_tx_rst;
      if (err && fail_at == 0) fail_at = n;
    end
    checks++;
    if (tx_entries != 2) begin errors++; $display("FAIL timeout_txrst_reentry got=%0d want=2", tx_entries); end
    checks++;
    if (fail_at != 353) begin errors++; $display("FAIL timeout_fail_cycle got=%0d want=353", fail_at); end
    checks++;
    if (obs !== FAIL_OUT) begin errors++; $display("FAIL timeout_fail_state got=%b want=%b", obs, FAIL_OUT); end
    for (int n = 0; n < 20; n++) begin
      run = 1'($urandom); qpll = 1'($urandom); tx_done = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== FAIL_OUT) begin
        errors++; $display("FAIL fail_sticky cyc=%0d got=%b want=%b", n, obs, FAIL_OUT);
      end
    end
    apply_reset();
    checks++;
    if (obs !== RESET_OUT) begin errors++; $display("FAIL fail_cleared got=%b want=%b", obs, RESET_OUT); end
  endtask

  task automatic test_link_loss();
    apply_reset();
    qpll = 1; tx_done = 1; rx_done = 1; hdr = 1; run = 1;
    repeat (37) @(negedge clk);
    checks++;
    if (link_ready !== 1'b1) begin errors++; $display("FAIL loss_initial_ready got=%b want=1", link_ready); end
    hdr = 0;
    repeat (3) @(negedge clk);
    hdr = 1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL glitch cyc=%0d got=%b want=%b", n, obs, model_out());
      end
    end
    checks++;
    if (obs !== 14'b00001_0_00000000) begin
      errors++; $display("FAIL glitch_ignored got=%b want=%b", obs, 14'b00001_0_00000000);
    end
    hdr = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (link_ready !== 1'b1) begin errors++; $display("FAIL loss_edge4 got=%b want=1", link_ready); end
    hdr = 1;
    @(negedge clk);
    checks++;
    if (obs !== 14'b01010_0_00000001) begin
      errors++; $display("FAIL loss_edge5 got=%b want=%b", obs, 14'b01010_0_00000001);
    end
    for (int n = 6; n <= 23; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL relock cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (n == 22 || n == 23) begin
        checks++;
        if (link_ready !== (n == 23)) begin
          errors++; $display("FAIL relock_ready cyc=%0d got=%b want=%b", n, link_ready, n == 23);
        end
      end
    end
  endtask

  task automatic test_qpll_loss();
    apply_reset();
    qpll = 1; tx_done = 1; rx_done = 1; hdr = 0; run = 1;
    repeat (40) @(negedge clk);
    checks++;
    if (obs !== W4LOCK_OUT) begin errors++; $display("FAIL qpll_w4lock got=%b want=%b", obs, W4LOCK_OUT); end
    qpll = 0;
    @(negedge clk);
    checks++;
    if (obs !== RESET_OUT) begin errors++; $display("FAIL qpll_drop got=%b want=%b", obs, RESET_OUT); end
    repeat (4) @(negedge clk);
    qpll = 1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL qpll_restart cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (n == 16 || n == 17) begin
        checks++;
        if (gtx_tx_rst !== (n == 16)) begin
          errors++; $display("FAIL qpll_txrst_len cyc=%0d got=%b want=%b", n, gtx_tx_rst, n == 16);
        end
      end
    end
  endtask

  task automatic test_timeout_coincide();
    apply_reset();
    qpll = 1; tx_done = 1; rx_done = 0; hdr = 0; run = 1;
    for (int n = 1; n <= 135; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL coincide_pre cyc=%0d got=%b want=%b", n, obs, model_out());
      end
    end
    checks++;
    if (obs !== W4RX_OUT) begin errors++; $display("FAIL coincide_w4rx got=%b want=%b", obs, W4RX_OUT); end
    rx_done = 1;
    @(negedge clk);
    checks++;
    if (obs !== W4LOCK_OUT) begin errors++; $display("FAIL coincide_lock got=%b want=%b", obs, W4LOCK_OUT); end
  endtask

  task automatic test_saturate();
    int waited;
    apply_reset();
    qpll = 1; tx_done = 1; rx_done = 1; hdr = 1; run = 1;
    repeat (37) @(negedge clk);
    for (int ev = 0; ev < 300; ev++) begin
      hdr = 0;
      repeat (T_LOSS_FILT) @(negedge clk);
      hdr = 1;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
        checks++;
        if (obs !== model_out()) begin
          errors++; $display("FAIL saturate ev=%0d got=%b want=%b", ev, obs, model_out());
        end
      end while (!link_ready && waited < 40);
      checks++;
      if (link_ready !== 1'b1) begin
        errors++; $display("FAIL saturate_relock_timeout ev=%0d got=%b want=1", ev, link_ready);
      end
    end
    checks++;
    if ({err, retry_cnt} !== 9'h0FF) begin
      errors++; $display("FAIL saturate_final err=%b retry=%0d want err=0 retry=255", err, retry_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    run = 1; qpll = 1; tx_done = 1; rx_done = 1; hdr = 1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if ($urandom_range(59) == 0) run     = ($urandom_range(9) != 0);
      if ($urandom_range(39) == 0) qpll    = ($urandom_range(7) != 0);
      if ($urandom_range(29) == 0) tx_done = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) rx_done = ($urandom_range(3) != 0);
      if ($urandom_range(7)  == 0) hdr     = ($urandom_range(3) != 0);
      rst = ($urandom_range(499) == 0);
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_timeout_fail();
    test_link_loss();
    test_qpll_loss();
    test_timeout_coincide();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
